// File: rtl/mem_data_dumper.sv
// Sequential reader for the BIP I data memory: walks addresses 0..DUMP_DEPTH-1 and
// streams every word, least-significant byte first, through the UART TX byte handshake.
module mem_data_dumper #(
   parameter int RAM_WIDTH    = 16,
   parameter int ADDR_WIDTH   = 11,
   parameter int DUMP_DEPTH   = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   output logic [ADDR_WIDTH-1:0] o_addr,
   input  logic [RAM_WIDTH-1:0]  i_data,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_start,
   input  logic                  i_tx_done,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int NBYTES = RAM_WIDTH / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LATENCY - 1);
   // Full-width compare, so DUMP_DEPTH = 2**ADDR_WIDTH never needs the overflowed address.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_SEND,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LAT_W-1:0]      r_lat;
   logic [IDX_W-1:0]      r_idx;
   logic [RAM_WIDTH-1:0]  r_word;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = S_READ;
            end
         end
         S_READ: begin
            if (r_lat == LAT_LAST) begin
               w_next = S_LOAD;
            end
         end
         S_LOAD: w_next = S_SEND;
         S_SEND: w_next = S_WAIT;
         S_WAIT: begin
            if (i_tx_done) begin
               if (r_idx != LAST_IDX) begin
                  w_next = S_SEND;
               end else if (r_addr != LAST_ADDR) begin
                  w_next = S_READ;
               end else begin
                  w_next = S_DONE;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address, latency counter, byte index and captured word follow the FSM transitions.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_addr <= '0;
         r_lat  <= '0;
         r_idx  <= '0;
         r_word <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_addr <= '0;
                  r_lat  <= '0;
               end
            end
            S_READ: begin
               if (r_lat != LAT_LAST) begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            S_LOAD: begin
               r_word <= i_data;
               r_idx  <= '0;
            end
            S_WAIT: begin
               if (i_tx_done) begin
                  if (r_idx != LAST_IDX) begin
                     r_idx <= r_idx + 1'b1;
                  end else if (r_addr != LAST_ADDR) begin
                     r_addr <= r_addr + 1'b1;
                     r_lat  <= '0;
                  end else begin
                     r_addr <= '0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      o_tx_start = (r_state == S_SEND);
      o_done     = (r_state == S_DONE);
      o_busy     = (r_state == S_READ) || (r_state == S_LOAD) ||
                   (r_state == S_SEND) || (r_state == S_WAIT);
   end

   // Byte lane select; idx only changes on a real done, so the byte holds through WAIT.
   always_comb begin
      o_tx_data = '0;
      for (int b = 0; b < NBYTES; b++) begin
         if (r_idx == IDX_W'(b)) begin
            o_tx_data = r_word[8*b +: 8];
         end
      end
   end

   assign o_addr = r_addr;

endmodule

// File: doc/mem_data_dumper.md
Name: mem_data_dumper

Overview:
- Sequential reader for the BIP I data memory (`memoria_datos`). It is the read-side counterpart of the write path that fills that memory.
- On a start pulse it walks addresses 0..DUMP_DEPTH-1 and captures each word from the memory's registered output.
- It splits each word into bytes and streams them, LSB first, through a byte-level handshake to the UART transmitter of the debug unit.
- It sits between `memoria_datos` (address out, data in) and `uart_tx` (start/data out, done in).

Parameters:
- RAM_WIDTH, 16, data memory word width; must be a multiple of 8. NBYTES = RAM_WIDTH/8.
- ADDR_WIDTH, 11, data memory address width.
- DUMP_DEPTH, 1024, number of words dumped per run; range 1..2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from o_addr change to valid i_data. 1 matches LOW_LATENCY; 2 matches HIGH_PERFORMANCE.

Ports:
- i_clk, input, 1, system clock, rising edge.
- i_reset, input, 1, synchronous, active-high reset.
- i_start, input, 1, one-cycle request to begin a dump.
- o_addr, output, ADDR_WIDTH, data memory read address; drives `memoria_datos` i_addr.
- i_data, input, RAM_WIDTH, data memory read data; driven by `memoria_datos` o_data.
- o_tx_data, output, 8, byte to transmit.
- o_tx_start, output, 1, one-cycle pulse: o_tx_data valid, begin transmission.
- i_tx_done, input, 1, one-cycle pulse from UART TX: byte fully sent.
- o_busy, output, 1, high from start acceptance until the end-of-dump pulse.
- o_done, output, 1, one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset: synchronous on the rising edge while i_reset=1. It overrides all other inputs, including in the middle of a dump, and returns to IDLE.
  - Reset values: o_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0.
  - Internal word register, byte index and latency counter are cleared.
- Block never writes the memory; the top level ties memoria_datos wea=0 while o_busy=1.
- FSM states: IDLE, READ, LOAD, SEND, WAIT, DONE.
- IDLE:
  - i_start=1 → READ, with o_addr=0 and o_busy=1 from the next cycle.
  - i_start=0 → stay in IDLE.
- READ: hold o_addr for READ_LATENCY cycles (latency counter), then → LOAD.
- LOAD: capture i_data into the word register, set byte index to 0, → SEND.
- SEND:
  - Drive o_tx_start=1 for exactly this one cycle.
  - o_tx_data = word[8*idx+7 : 8*idx].
  - → WAIT.
- WAIT: hold o_tx_data stable until i_tx_done=1, then:
  - idx < NBYTES-1: idx+1, → SEND.
  - idx = NBYTES-1 and o_addr < DUMP_DEPTH-1: o_addr+1, → READ.
  - idx = NBYTES-1 and o_addr = DUMP_DEPTH-1: → DONE.
- DONE:
  - o_done=1 for one cycle, o_busy=0 in the same cycle, o_addr=0.
  - → IDLE.
- Latency, start to first o_tx_start: start edge + 1 (READ) + READ_LATENCY + 1 (LOAD) → SEND. This is 3 cycles after the accepting edge for READ_LATENCY=1.
- Byte spacing: the next o_tx_start occurs exactly 1 cycle after the i_tx_done of the previous byte within a word.
- Word spacing: READ_LATENCY+2 cycles after the i_tx_done of the last byte of a word.
- Ignored inputs:
  - i_start while o_busy=1, or in the DONE cycle: ignored, no restart and no queueing.
  - i_tx_done outside WAIT, including the SEND cycle itself: ignored. A stray done must not advance the FSM or skip a byte.
- o_tx_start is never asserted outside SEND and never asserted for 2 consecutive cycles.
- Address arithmetic:
  - o_addr increments by 1 without wrap.
  - DUMP_DEPTH = 2^ADDR_WIDTH is legal: the comparison against DUMP_DEPTH-1 is performed at full ADDR_WIDTH precision, so no overflow occurs before DONE.
- DUMP_DEPTH=1: exactly NBYTES bytes sent, then DONE.
- Reset during WAIT: o_tx_start stays 0 afterwards. A pending i_tx_done after reset is ignored because the FSM is in IDLE.

Test Plan:
- Basic dump: memory model with word0=16'h000F, word1=16'h0002, DUMP_DEPTH=2, READ_LATENCY=1, UART model answering done 10 cycles after each start.
  - Required bytes: 8'h0F, 8'h00, 8'h02, 8'h00.
  - Exactly 4 o_tx_start pulses.
  - o_done pulses once, 1 cycle after the 4th i_tx_done.
  - o_busy falls in the same cycle as o_done.
- Latency check: assert i_start; first o_tx_start occurs exactly 3 cycles after the accepting edge; o_addr=0 throughout READ.
  - Repeat with READ_LATENCY=2: 4 cycles.
- Busy restart: pulse i_start again while the 2nd byte is in WAIT.
  - Byte sequence is unchanged; still a single o_done; o_addr never returns to 0 mid-run.
- Stray done: assert i_tx_done in the SEND cycle and again while in READ.
  - No byte is skipped; o_tx_data for each byte is held until the real done.
- Reset mid-dump: assert i_reset for 1 cycle during WAIT of word1's low byte.
  - Next cycle: o_addr=0, o_busy=0, o_tx_start=0, no o_done.
  - A fresh i_start restarts from byte 8'h0F.
- Full range: DUMP_DEPTH=1024, word k = k.
  - 2048 bytes, with the final pair 8'hFF, 8'h03.
  - o_addr peaks at 1023 then reads 0 in the DONE cycle.
